// File: rtl/vector_lsu_pkg.sv
// Shared types and constants for the vector load/store initiator.
// Lane i of a vector access touches byte address base + LANE_STRIDE*i.
package vlsu_pkg;

    localparam int ADDR_W      = 20;
    localparam int LANES       = 8;
    localparam int LANE_STRIDE = 8;

    typedef logic [7:0][7:0] vec_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STORE
    } lsu_state_t;

    // Address of the highest byte touched by a request, one bit wider so overflow is visible.
    function automatic logic [ADDR_W:0] last_lane_addr(input logic [ADDR_W-1:0] addr,
                                                       input logic [2:0]        beats);
        logic [ADDR_W:0] lane_span;
        lane_span      = (ADDR_W+1)'((LANES - 1) * LANE_STRIDE);
        last_lane_addr = {1'b0, addr} + (ADDR_W+1)'(beats) + lane_span;
    endfunction

endpackage

// File: rtl/vector_lsu.sv
// Vector load/store initiator: splits a 1..8 beat request into strided memory accesses
// with valid/ready handshakes on requests, store data and load data.
module vector_lsu
    import vlsu_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 320,
    parameter int MEM_DEPTH    = IMAGE_WIDTH * IMAGE_HEIGHT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_beats,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  vec_t              wd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output vec_t              rd_data,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output vec_t              mem_wd,
    input  vec_t              mem_rd
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(MEM_DEPTH);

    lsu_state_t        r_state;
    logic [ADDR_W-1:0] r_base;
    logic [2:0]        r_beats;
    logic [2:0]        r_idx;
    logic              r_rd_valid;
    vec_t              r_rd_data;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    vec_t              r_mem_wd;

    logic              w_req_ready;
    logic              w_wd_ready;
    logic              w_accept;
    logic              w_in_range;
    logic [ADDR_W:0]   w_last;
    logic              w_capture;
    logic              w_wd_fire;
    logic              w_final;
    logic [ADDR_W-1:0] w_beat_addr;
    logic [ADDR_W-1:0] w_next_addr;

    // A pending load beat blocks new requests so the consumer never sees beats interleave.
    assign w_req_ready = (r_state == IDLE) && !r_rd_valid;
    assign w_wd_ready  = (r_state == STORE);
    assign w_accept    = req_valid && w_req_ready;
    assign w_last      = last_lane_addr(req_addr, req_beats);
    assign w_in_range  = (w_last < DEPTH_W);
    assign w_capture   = (r_state == LOAD) && (!r_rd_valid || rd_ready);
    assign w_wd_fire   = wd_valid && w_wd_ready;
    assign w_final     = (r_idx == r_beats);
    assign w_beat_addr = r_base + ADDR_W'(r_idx);
    assign w_next_addr = w_beat_addr + ADDR_W'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_beats    <= '0;
            r_idx      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_mem_addr <= '0;
            r_mem_we   <= 1'b0;
            r_mem_wd   <= '0;
        end else begin
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_mem_we <= 1'b0;
            if (r_rd_valid && rd_ready) begin
                r_rd_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (!w_in_range) begin
                            r_err <= 1'b1;
                        end else begin
                            r_base     <= req_addr;
                            r_beats    <= req_beats;
                            r_idx      <= '0;
                            r_mem_addr <= req_addr;
                            r_state    <= req_store ? STORE : LOAD;
                        end
                    end
                end
                LOAD: begin
                    // Address advances only when a beat is captured, so it holds across stalls.
                    if (w_capture) begin
                        r_rd_data  <= mem_rd;
                        r_rd_valid <= 1'b1;
                        r_idx      <= r_idx + 3'd1;
                        r_mem_addr <= w_next_addr;
                        if (w_final) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                STORE: begin
                    if (w_wd_fire) begin
                        r_mem_addr <= w_beat_addr;
                        r_mem_wd   <= wd_data;
                        r_mem_we   <= 1'b1;
                        r_idx      <= r_idx + 3'd1;
                        if (w_final) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign wd_ready  = w_wd_ready;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign done      = r_done;
    assign err       = r_err;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wd    = r_mem_wd;

endmodule
